// File: rtl/ext_aes_block_sequencer.sv
// Sequencer for the AES-128 extension ops: streams N 128-bit words memory -> AES core -> memory,
// one 32-bit beat at a time, stalling the pipeline while it runs.
module ext_aes_block_sequencer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              stall_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              core_start,
    output logic              core_mode,
    output logic [127:0]      core_din,
    input  logic [127:0]      core_dout,
    input  logic              core_done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_KICK  = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t            state;
    logic [1:0]        beat;
    logic [1:0]        beat_nx;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [127:0]      result;

    assign stall_pc  = busy;
    assign state_dbg = state;
    assign beat_nx   = beat + 2'd1;

    // src_ptr/dst_ptr always hold the address of the next beat to issue, so
    // mem_addr is simply loaded from them and wraps naturally modulo 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            core_din   <= '0;
            beat       <= '0;
            word_idx   <= '0;
            cnt        <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        cnt       <= count;
                        core_mode <= (mode == 3'd2);
                        beat      <= '0;
                        word_idx  <= '0;
                        dst_ptr   <= dst_addr;
                        if (count == '0 || !(mode == 3'd1 || mode == 3'd2)) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            mem_re   <= 1'b1;
                            mem_addr <= src_addr;
                            src_ptr  <= src_addr + ADDR_W'(4);
                        end
                    end
                end
                S_LOAD: begin
                    if (mem_ready) begin
                        core_din[{beat, 5'b0} +: 32] <= mem_rdata;
                        if (beat == 2'd3) begin
                            mem_re     <= 1'b0;
                            core_start <= 1'b1;
                            beat       <= '0;
                            state      <= S_KICK;
                        end else begin
                            beat     <= beat_nx;
                            mem_addr <= src_ptr;
                            src_ptr  <= src_ptr + ADDR_W'(4);
                        end
                    end
                end
                S_KICK: begin
                    core_start <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        result    <= core_dout;
                        mem_we    <= 1'b1;
                        mem_addr  <= dst_ptr;
                        mem_wdata <= core_dout[31:0];
                        dst_ptr   <= dst_ptr + ADDR_W'(4);
                        beat      <= '0;
                        state     <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (mem_ready) begin
                        if (beat == 2'd3) begin
                            mem_we   <= 1'b0;
                            beat     <= '0;
                            word_idx <= word_idx + CNT_W'(1);
                            // Compare before incrementing so count = 2**CNT_W-1 cannot overflow.
                            if (word_idx == cnt - CNT_W'(1)) begin
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                mem_re   <= 1'b1;
                                mem_addr <= src_ptr;
                                src_ptr  <= src_ptr + ADDR_W'(4);
                                state    <= S_LOAD;
                            end
                        end else begin
                            beat      <= beat_nx;
                            mem_addr  <= dst_ptr;
                            mem_wdata <= result[{beat_nx, 5'b0} +: 32];
                            dst_ptr   <= dst_ptr + ADDR_W'(4);
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
